rv64_int_exec_unit: RTL and testbench

//  RV64I integer execute slice: decoder, 32x64 register file and ALU in a 3-stage pipeline.

---
 rtl/rv64_int_exec_unit.sv | 200 ++++++++++++++++++++
 tb/tb_rv64_int_exec_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rv64_int_exec_unit.sv
// RV64I integer execute slice: decode + regfile read (ID), ALU (EX), register write (WB).
// Optional operand forwarding from EX and WB stages is enabled by defining REG_BYPASS_EN.
module rv64_int_exec_unit #(
   parameter int              XLEN        = 64,
   parameter logic [XLEN-1:0] REG_RST_VAL = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            instr_valid,
   input  logic [31:0]     instruction,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            illegal,
   input  logic [4:0]      dbg_addr,
   output logic [XLEN-1:0] dbg_data
);

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
   } alu_op_e;

   function automatic alu_op_e f3_op(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  f3_op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  f3_op = ALU_SLL;
         3'b010:  f3_op = ALU_SLT;
         3'b011:  f3_op = ALU_SLTU;
         3'b100:  f3_op = ALU_XOR;
         3'b101:  f3_op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  f3_op = ALU_OR;
         default: f3_op = ALU_AND;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] alu_f(input alu_op_e op, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b, input logic w);
      logic signed [XLEN-1:0] sa, sb;
      logic signed [31:0]     sa32;
      logic [31:0]            r32;
      logic [XLEN-1:0]        r;
      sa   = a;
      sb   = b;
      sa32 = a[31:0];
      r32  = '0;
      r    = '0;
      if (w) begin
         case (op)
            ALU_ADD: r32 = a[31:0] + b[31:0];
            ALU_SUB: r32 = a[31:0] - b[31:0];
            ALU_SLL: r32 = a[31:0] << b[4:0];
            ALU_SRL: r32 = a[31:0] >> b[4:0];
            ALU_SRA: r32 = sa32 >>> b[4:0];
            default: r32 = '0;
         endcase
         r = {{(XLEN-32){r32[31]}}, r32};
      end else begin
         case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << b[5:0];
            ALU_SLT:  r = {{(XLEN-1){1'b0}}, sa < sb};
            ALU_SLTU: r = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> b[5:0];
            ALU_SRA:  r = sa >>> b[5:0];
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            default:  r = b;
         endcase
      end
      alu_f = r;
   endfunction

   logic [XLEN-1:0] regs [32];

   logic [6:0]      opc;
   logic [4:0]      rd, rs1, rs2;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] imm_i, imm_u, rs1_val, rs2_val, opb;
   alu_op_e         op_d;
   logic            w_d, legal_d;

   logic            vld_p0, w_p0;
   logic [4:0]      rd_p0;
   alu_op_e         op_p0;
   logic [XLEN-1:0] a_p0, b_p0, ex_res;

   logic            vld_p1, illegal_p1;
   logic [4:0]      rd_p1;
   logic [XLEN-1:0] data_p1;

   assign opc   = instruction[6:0];
   assign rd    = instruction[11:7];
   assign f3    = instruction[14:12];
   assign rs1   = instruction[19:15];
   assign rs2   = instruction[24:20];
   assign f7    = instruction[31:25];
   assign imm_i = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
   assign imm_u = {{(XLEN-32){instruction[31]}}, instruction[31:12], 12'b0};

   assign ex_res = alu_f(op_p0, a_p0, b_p0, w_p0);

   // ID: operand read, optionally forwarded from younger in-flight results
   always_comb begin
      rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
      rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];
`ifdef REG_BYPASS_EN
      if (vld_p1 && rd_p1 != 5'd0 && rd_p1 == rs1) rs1_val = data_p1;
      if (vld_p1 && rd_p1 != 5'd0 && rd_p1 == rs2) rs2_val = data_p1;
      if (vld_p0 && rd_p0 != 5'd0 && rd_p0 == rs1) rs1_val = ex_res;
      if (vld_p0 && rd_p0 != 5'd0 && rd_p0 == rs2) rs2_val = ex_res;
`endif
   end

   // ID: decode and legality of the f7 / shift fields
   always_comb begin
      op_d    = ALU_ADD;
      w_d     = 1'b0;
      legal_d = 1'b0;
      opb     = rs2_val;
      case (opc)
         7'b0110011: begin
            op_d    = f3_op(f3, f7[5]);
            legal_d = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
         end
         7'b0010011: begin
            opb  = imm_i;
            op_d = f3_op(f3, (f3 == 3'b101) && instruction[30]);
            case (f3)
               3'b001:  legal_d = (instruction[31:26] == 6'b000000);
               3'b101:  legal_d = (instruction[31:26] == 6'b000000) ||
                                  (instruction[31:26] == 6'b010000);
               default: legal_d = 1'b1;
            endcase
         end
         7'b0111011, 7'b0011011: begin
            w_d  = 1'b1;
            opb  = opc[5] ? rs2_val : imm_i;
            op_d = f3_op(f3, (opc[5] || f3 == 3'b101) && f7[5]);
            case (f3)
               3'b000:  legal_d = !opc[5] || f7 == 7'h00 || f7 == 7'h20;
               3'b001:  legal_d = (f7 == 7'h00);
               3'b101:  legal_d = (f7 == 7'h00) || (f7 == 7'h20);
               default: legal_d = 1'b0;
            endcase
         end
         7'b0110111: begin
            op_d    = ALU_PASSB;
            opb     = imm_u;
            legal_d = 1'b1;
         end
         default: legal_d = 1'b0;
      endcase
   end

   // ID/EX boundary
   always_ff @(posedge clk) begin
      rd_p0 <= rd;
      op_p0 <= op_d;
      w_p0  <= w_d;
      a_p0  <= rs1_val;
      b_p0  <= opb;
   end

   // EX/WB boundary and control
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p0     <= 1'b0;
         vld_p1     <= 1'b0;
         illegal_p1 <= 1'b0;
         rd_p1      <= '0;
         data_p1    <= '0;
      end else begin
         vld_p0     <= instr_valid && legal_d;
         illegal_p1 <= instr_valid && !legal_d;
         vld_p1     <= vld_p0;
         rd_p1      <= rd_p0;
         data_p1    <= ex_res;
      end
   end

   // WB: register write
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= REG_RST_VAL;
      end else if (vld_p1 && rd_p1 != 5'd0) begin
         regs[rd_p1] <= data_p1;
      end
   end

   assign wb_valid = vld_p1;
   assign wb_rd    = rd_p1;
   assign wb_data  = data_p1;
   assign illegal  = illegal_p1;
   assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_rv64_int_exec_unit.sv
// Directed-vector bench for rv64_int_exec_unit; expected values are hand-computed constants.
module tb_rv64_int_exec_unit;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OPIMM  = 7'b0010011;
   localparam logic [6:0] OPIMMW = 7'b0011011;
   localparam logic [6:0] LUI    = 7'b0110111;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        instr_valid = 1'b0;
   logic [31:0] instruction = '0;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        illegal;
   logic [4:0]  dbg_addr = '0;
   logic [63:0] dbg_data;

   int errors = 0;
   int checks = 0;

   rv64_int_exec_unit dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] opc);
      return {f7, rs2, rs1, f3, rd, opc};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one cycle: drive at the falling edge, outputs are stable here
   task automatic tick(input logic v, input logic [31:0] ins);
      @(negedge clk);
      instr_valid = v;
      instruction = ins;
   endtask

   task automatic bubbles(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 32'h0);
   endtask

   task automatic check_reg(input string tag, input logic [4:0] r, input logic [63:0] exp);
      dbg_addr = r;
      #1;
      check(tag, dbg_data, exp);
   endtask

   logic [63:0] exp_x8;

   initial begin
      bubbles(2);
      tick(1'b0, 32'h0);
      reset = 1'b0;
      bubbles(1);
      check("rst_wb_valid", {63'b0, wb_valid}, 64'd0);
      check("rst_wb_rd", {59'b0, wb_rd}, 64'd0);
      check("rst_wb_data", wb_data, 64'd0);
      check("rst_illegal", {63'b0, illegal}, 64'd0);
      check_reg("rst_x1", 5'd1, 64'd0);

      // 1: ADDI x1,x0,5
      tick(1'b1, enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPIMM));
      tick(1'b0, 32'h0);
      check("t1_early_wb", {63'b0, wb_valid}, 64'd0);
      check("t1_no_illegal", {63'b0, illegal}, 64'd0);
      tick(1'b0, 32'h0);
      check("t1_wb_valid", {63'b0, wb_valid}, 64'd1);
      check("t1_wb_rd", {59'b0, wb_rd}, 64'd1);
      check("t1_wb_data", wb_data, 64'd5);
      tick(1'b0, 32'h0);
      check_reg("t1_dbg_x1", 5'd1, 64'd5);

      // 2: shifts of all-ones, wrap-around, signed/unsigned compare
      tick(1'b1, enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, OPIMM));
      bubbles(3);
      tick(1'b1, enc_i(12'd60, 5'd1, 3'b101, 5'd2, OPIMM));
      tick(1'b1, enc_i(12'h43C, 5'd1, 3'b101, 5'd3, OPIMM));
      tick(1'b1, enc_i(12'd1, 5'd1, 3'b101, 5'd10, OPIMM));
      tick(1'b0, 32'h0);
      check("t2_wb_srai_rd", {59'b0, wb_rd}, 64'd3);
      check("t2_wb_srai", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
      bubbles(2);
      check_reg("t2_x2", 5'd2, 64'hF);
      check_reg("t2_x3", 5'd3, 64'hFFFF_FFFF_FFFF_FFFF);
      check_reg("t2_x10", 5'd10, 64'h7FFF_FFFF_FFFF_FFFF);
      tick(1'b1, enc_i(12'd1, 5'd10, 3'b000, 5'd11, OPIMM));
      bubbles(3);
      tick(1'b1, enc_r(7'h00, 5'd0, 5'd11, 3'b010, 5'd12, OP));
      tick(1'b1, enc_r(7'h00, 5'd0, 5'd11, 3'b011, 5'd13, OP));
      bubbles(3);
      check_reg("t2_wrap_x11", 5'd11, 64'h8000_0000_0000_0000);
      check_reg("t2_slt_x12", 5'd12, 64'd1);
      check_reg("t2_sltu_x13", 5'd13, 64'd0);

      // 3: LUI and word ops
      tick(1'b1, {20'h80000, 5'd4, LUI});
      bubbles(3);
      tick(1'b1, enc_i(12'd0, 5'd4, 3'b000, 5'd5, OPIMMW));
      tick(1'b1, enc_r(7'h00, 5'd4, 5'd0, 3'b011, 5'd6, OP));
      tick(1'b1, enc_i(12'h404, 5'd4, 3'b101, 5'd14, OPIMMW));
      tick(1'b1, enc_i(12'h004, 5'd4, 3'b101, 5'd15, OPIMMW));
      bubbles(3);
      check_reg("t3_lui_x4", 5'd4, 64'hFFFF_FFFF_8000_0000);
      check_reg("t3_addiw_x5", 5'd5, 64'hFFFF_FFFF_8000_0000);
      check_reg("t3_sltu_x6", 5'd6, 64'd1);
      check_reg("t3_sraiw_x14", 5'd14, 64'hFFFF_FFFF_F800_0000);
      check_reg("t3_srliw_x15", 5'd15, 64'h0000_0000_0800_0000);

      // 4: back-to-back dependency
`ifdef REG_BYPASS_EN
      exp_x8 = 64'd6;
`else
      exp_x8 = 64'd0;
`endif
      tick(1'b1, enc_i(12'd3, 5'd0, 3'b000, 5'd7, OPIMM));
      tick(1'b1, enc_r(7'h00, 5'd7, 5'd7, 3'b000, 5'd8, OP));
      bubbles(3);
      check_reg("t4_x7", 5'd7, 64'd3);
      check_reg("t4_dep_x8", 5'd8, exp_x8);

      // 5: write to x0, then illegal encodings
      tick(1'b1, enc_i(12'd9, 5'd0, 3'b000, 5'd0, OPIMM));
      tick(1'b1, 32'h0000_0000);
      tick(1'b1, enc_r(7'h20, 5'd1, 5'd1, 3'b110, 5'd9, OP));
      check("t5_illegal_zero", {63'b0, illegal}, 64'd1);
      check("t5_x0_wb_valid", {63'b0, wb_valid}, 64'd1);
      check("t5_x0_wb_rd", {59'b0, wb_rd}, 64'd0);
      check("t5_x0_wb_data", wb_data, 64'd9);
      tick(1'b0, 32'h0);
      check("t5_illegal_f7", {63'b0, illegal}, 64'd1);
      check("t5_no_wb_zero", {63'b0, wb_valid}, 64'd0);
      tick(1'b0, 32'h0);
      check("t5_illegal_clear", {63'b0, illegal}, 64'd0);
      check("t5_no_wb_f7", {63'b0, wb_valid}, 64'd0);
      check_reg("t5_dbg_x0", 5'd0, 64'd0);
      check_reg("t5_x9_untouched", 5'd9, 64'd0);

      // 6: reset with two instructions in flight
      tick(1'b1, enc_i(12'd1, 5'd0, 3'b000, 5'd16, OPIMM));
      tick(1'b1, enc_i(12'd2, 5'd0, 3'b000, 5'd17, OPIMM));
      tick(1'b0, 32'h0);
      reset = 1'b1;
      tick(1'b0, 32'h0);
      reset = 1'b0;
      check("t6_wb_after_rst", {63'b0, wb_valid}, 64'd0);
      tick(1'b0, 32'h0);
      check("t6_wb_after_rst2", {63'b0, wb_valid}, 64'd0);
      tick(1'b0, 32'h0);
      check("t6_wb_after_rst3", {63'b0, wb_valid}, 64'd0);
      for (int r = 0; r < 32; r++) check_reg($sformatf("t6_x%0d", r), 5'(r), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
